fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 16: cycles the enable is held for divide.
REQ-002 Parameter SQRT_CYCLES, default 16: cycles the enable is held for square root.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  4  opcode 0..9 = add, sub, mul, div, sqrt, max, min, eq, lt, leq
- req_a, req_b  in  32  IEEE-754 single operands
- read_data1, read_data2  out  32  operands to the FP ALU
- alu_en  out  10  one-hot enables, bit9..0 = add, sub, mul, div, sqrt, max, min, eq, lt, leq
- alu_data_out  in  32  registered FP ALU result
- rsp_valid  out  1  result present
- rsp_ready  in  1  result consumed when high with rsp_valid
- rsp_data  out  32  result
- rsp_op  out  4  opcode of the result
- rsp_err  out  1  illegal-opcode flag
- busy  out  1  high whenever state != IDLE

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, CAPTURE and RESP.
REQ-006 req_ready SHALL equal (state==IDLE).
- On acceptance: latch req_a/req_b into read_data1/read_data2, latch req_op, go to ISSUE.
REQ-007 read_data1/read_data2 SHALL stay constant from acceptance until the next acceptance.
REQ-008 In ISSUE, alu_en SHALL drive exactly the one bit for the latched opcode. In every other state alu_en SHALL be 0.
REQ-009 ISSUE SHALL last N cycles, then go to CAPTURE:
- N = DIV_CYCLES for div
- N = SQRT_CYCLES for sqrt
- N = 1 for all other ops
- ISSUE uses a down-counter loaded on acceptance.
REQ-010 In CAPTURE (one cycle), rsp_data SHALL be loaded from alu_data_out at the closing edge, then the FSM goes to RESP.
REQ-011 In RESP, rsp_valid SHALL be high. rsp_data, rsp_op and rsp_err SHALL be stable until rsp_ready is sampled high; then the FSM goes to IDLE.
REQ-012 Latency: rsp_valid SHALL rise N+2 cycles after the acceptance edge (3 cycles for single-cycle ops).
REQ-013 Throughput: at most one request in flight. The next request SHALL NOT be accepted in the same cycle the response is consumed; the earliest acceptance is the following cycle.
REQ-014 alu_en SHALL never have more than one bit set in any cycle, including reset exit.

Reset
REQ-015 While rst_n is low, all outputs SHALL immediately go to: state IDLE, alu_en=0, read_data1=read_data2=0, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0, busy=0, counter=0.
REQ-016 Assertion of rst_n mid-operation SHALL abort the operation; no response SHALL be produced for it.
REQ-017 After rst_n deasserts, req_ready SHALL be high on the first clock cycle.

Configuration
REQ-018 Macro FPU_OP_ERR_EN controls illegal-opcode handling (opcodes 10..15).
- Defined: acceptance goes directly to RESP, skipping ISSUE and CAPTURE, with rsp_data=0 and rsp_err=1. rsp_valid rises 1 cycle after acceptance.
- Undefined: rsp_err is tied to 0. The opcode takes the single-cycle path with alu_en=0 and returns alu_data_out as captured.

Structure
REQ-019 Package fpu_pkg SHALL hold:
- the opcode enumeration
- the alu_en bit-index constants
- the FSM state type
- the default DIV_CYCLES/SQRT_CYCLES values
REQ-020 Sub-module fpu_op_decode (combinational) SHALL map an opcode to the one-hot enable, the cycle count and a legal flag.

Verification
REQ-021 Add: req_op=0, a=0x3F800000, b=0x40000000, ALU model returns 0x40400000. Required: alu_en=0x200 for exactly 1 cycle; rsp_valid rises 3 cycles after acceptance; rsp_data=0x40400000.
REQ-022 Div with DIV_CYCLES=16: alu_en=0x040 held exactly 16 cycles; rsp_valid 18 cycles after acceptance; req_ready low throughout.
REQ-023 Backpressure: rsp_ready held low 5 cycles. Required: rsp_valid/rsp_data stable for all 5 cycles; no acceptance while low; req_ready rises the cycle after the handshake.
REQ-024 Reset: rst_n pulsed low during sqrt ISSUE cycle 4. Required: alu_en=0 immediately; no rsp_valid afterwards; req_ready=1 on the first cycle after release.
REQ-025 Illegal opcode 12:
- With FPU_OP_ERR_EN: rsp_err=1, rsp_data=0, latency 1, alu_en never nonzero.
- Without: rsp_err=0, latency 3.
REQ-026 Random back-to-back ops (1000): checker asserts $onehot0(alu_en) every cycle and rsp_op matches request order.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP ALU issue controller.
package fpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SQRT = 4'd4,
    OP_MAX  = 4'd5,
    OP_MIN  = 4'd6,
    OP_EQ   = 4'd7,
    OP_LT   = 4'd8,
    OP_LEQ  = 4'd9
  } fpu_op_e;

  // Bit positions inside the one-hot alu_en vector
  localparam int EN_ADD  = 9;
  localparam int EN_SUB  = 8;
  localparam int EN_MUL  = 7;
  localparam int EN_DIV  = 6;
  localparam int EN_SQRT = 5;
  localparam int EN_MAX  = 4;
  localparam int EN_MIN  = 3;
  localparam int EN_EQ   = 2;
  localparam int EN_LT   = 1;
  localparam int EN_LEQ  = 0;
  localparam int ALU_EN_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } fpu_state_e;

  localparam int DEF_DIV_CYCLES  = 16;
  localparam int DEF_SQRT_CYCLES = 16;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational opcode decode: one-hot ALU enable, issue cycle count, legal flag.
module fpu_op_decode
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int SQRT_CYCLES = DEF_SQRT_CYCLES,
  parameter int CNT_W       = 5
) (
  input  logic [3:0]          op,
  output logic [ALU_EN_W-1:0] en,
  output logic [CNT_W-1:0]    cycles,
  output logic                legal
);

  always_comb begin
    en     = '0;
    cycles = CNT_W'(1);
    legal  = 1'b1;
    case (op)
      OP_ADD:  en[EN_ADD] = 1'b1;
      OP_SUB:  en[EN_SUB] = 1'b1;
      OP_MUL:  en[EN_MUL] = 1'b1;
      OP_DIV: begin
        en[EN_DIV] = 1'b1;
        cycles     = CNT_W'(DIV_CYCLES);
      end
      OP_SQRT: begin
        en[EN_SQRT] = 1'b1;
        cycles      = CNT_W'(SQRT_CYCLES);
      end
      OP_MAX:  en[EN_MAX] = 1'b1;
      OP_MIN:  en[EN_MIN] = 1'b1;
      OP_EQ:   en[EN_EQ]  = 1'b1;
      OP_LT:   en[EN_LT]  = 1'b1;
      OP_LEQ:  en[EN_LEQ] = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller between a request port and a registered FP ALU.
// Optional FPU_OP_ERR_EN: illegal opcodes answer immediately with rsp_err=1.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int SQRT_CYCLES = DEF_SQRT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  output logic [31:0]         read_data1,
  output logic [31:0]         read_data2,
  output logic [ALU_EN_W-1:0] alu_en,
  input  logic [31:0]         alu_data_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [3:0]          rsp_op,
  output logic                rsp_err,
  output logic                busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > SQRT_CYCLES) ? DIV_CYCLES : SQRT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  fpu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ALU_EN_W-1:0] alu_en_q, alu_en_d;
  logic [3:0]          op_q, op_d;
  logic [31:0]         rd1_q, rd1_d, rd2_q, rd2_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;

  logic [ALU_EN_W-1:0] dec_en;
  logic [CNT_W-1:0]    dec_cycles;
  logic                dec_legal;
  logic                err_path;

  fpu_op_decode #(
    .DIV_CYCLES  (DIV_CYCLES),
    .SQRT_CYCLES (SQRT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_decode (
    .op     (req_op),
    .en     (dec_en),
    .cycles (dec_cycles),
    .legal  (dec_legal)
  );

`ifdef FPU_OP_ERR_EN
  assign err_path = !dec_legal;
`else
  // Illegal opcodes fall through the single-cycle path with no enable set.
  logic unused_legal;
  assign unused_legal = dec_legal;
  assign err_path     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_en_d    = alu_en_q;
    op_d        = op_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rd1_d     = req_a;
          rd2_d     = req_b;
          op_d      = req_op;
          rsp_err_d = 1'b0;
          if (err_path) begin
            state_d     = ST_RESP;
            cnt_d       = '0;
            alu_en_d    = '0;
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            cnt_d    = dec_cycles;
            alu_en_d = dec_en;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Enable drops on the same edge the last issue cycle closes.
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = ST_CAPTURE;
          cnt_d    = '0;
          alu_en_d = '0;
        end
      end
      ST_CAPTURE: begin
        state_d     = ST_RESP;
        rsp_data_d  = alu_data_out;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_en_q    <= '0;
      op_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_en_q    <= alu_en_d;
      op_q        <= op_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign alu_en     = alu_en_q;
  assign read_data1 = rd1_q;
  assign read_data2 = rd2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_op     = op_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized self-checking bench for fpu_issue_ctrl against a transaction-level model.
module tb_fpu_issue_ctrl;

  localparam int DIV_N  = 16;
  localparam int SQRT_N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] read_data1, read_data2;
  logic [9:0]  alu_en;
  logic [31:0] alu_data_out = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_op;
  logic        rsp_err;
  logic        busy;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] ref_last = 32'h0;
  logic [3:0]  exp_ops[$];

  fpu_issue_ctrl #(.DIV_CYCLES(DIV_N), .SQRT_CYCLES(SQRT_N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .alu_en       (alu_en),
    .alu_data_out (alu_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_op       (rsp_op),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU result; 1.0 + 2.0 gives the real IEEE sum.
  function automatic logic [31:0] alu_fn(input logic [9:0] en, input logic [31:0] a,
                                         input logic [31:0] b);
    if (en == 10'h200 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[30:0], b[31]}) + {22'h0, en};
  endfunction

  always @(posedge clk)
    if (alu_en != 10'h0) alu_data_out <= alu_fn(alu_en, read_data1, read_data2);

  function automatic logic [9:0] exp_en(input logic [3:0] op);
    return (op <= 4'd9) ? (10'h200 >> op) : 10'h0;
  endfunction

  function automatic int n_of(input logic [3:0] op);
    if (op == 4'd3) return DIV_N;
    if (op == 4'd4) return SQRT_N;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (mon_en) check("onehot0_alu_en", {31'h0, $onehot0(alu_en)}, 32'h1);

  // Entered and left just after a falling edge; drives one full transaction.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int bp);
    logic [9:0]  en;
    logic [31:0] dat;
    logic [3:0]  got_op;
    logic        err;
    int n, lat, c, w;
    en = exp_en(op);
`ifdef FPU_OP_ERR_EN
    err = (op > 4'd9);
`else
    err = 1'b0;
`endif
    if (err) begin
      n = 0; lat = 1; dat = 32'h0;
    end else begin
      n = n_of(op); lat = n + 2;
      if (op <= 4'd9) begin
        dat = alu_fn(en, a, b);
        ref_last = dat;
      end else dat = ref_last;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
    w = 0;
    while (!req_ready && w < 8) begin @(negedge clk); w++; end
    check("accept_ready", {31'h0, req_ready}, 32'h1);
    exp_ops.push_back(op);
    c = 1;
    @(negedge clk);
    while (!rsp_valid && c < 60) begin
      check("alu_en", {22'h0, alu_en}, (c <= n) ? {22'h0, en} : 32'h0);
      check("busy", {31'h0, busy}, 32'h1);
      check("ready_low", {31'h0, req_ready}, 32'h0);
      check("read_data1", read_data1, a);
      @(negedge clk);
      c++;
    end
    check("latency", c, lat);
    got_op = (exp_ops.size() > 0) ? exp_ops.pop_front() : 4'hx;
    check("rsp_op", {28'h0, rsp_op}, {28'h0, got_op});
    check("rsp_data", rsp_data, dat);
    check("rsp_err", {31'h0, rsp_err}, {31'h0, err});
    check("alu_en_resp", {22'h0, alu_en}, 32'h0);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("bp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_data", rsp_data, dat);
      check("bp_op", {28'h0, rsp_op}, {28'h0, op});
      check("bp_ready_low", {31'h0, req_ready}, 32'h0);
      check("bp_read_data2", read_data2, b);
    end
    // req_valid stays high through the handshake cycle; it must not be taken there.
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("valid_drop", {31'h0, rsp_valid}, 32'h0);
    check("ready_after_hs", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    logic       seen;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_a = 32'h0; req_b = 32'h0;
    rsp_ready = 1'b0;
    #1;
    check("rst_alu_en", {22'h0, alu_en}, 32'h0);
    check("rst_rd1", read_data1, 32'h0);
    check("rst_rd2", read_data2, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_op", {28'h0, rsp_op}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'h0, req_ready}, 32'h1);
    mon_en = 1'b1;

    do_op(4'd0, 32'h3F800000, 32'h40000000, 0);
    do_op(4'd3, 32'h12345678, 32'h9ABCDEF0, 0);
    do_op(4'd2, 32'hC0000000, 32'h3F000000, 5);
    do_op(4'd12, 32'h11111111, 32'h22222222, 1);

    // Abort a square root in its fourth issue cycle.
    req_valid = 1'b1; req_op = 4'd4; req_a = 32'h40800000; req_b = 32'h0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("sqrt_en_c4", {22'h0, alu_en}, 32'h020);
    ref_last = alu_fn(10'h020, 32'h40800000, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_alu_en", {22'h0, alu_en}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_rd1", read_data1, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", {31'h0, req_ready}, 32'h1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_abort", {31'h0, seen}, 32'h0);

    do_op(4'd12, 32'h33333333, 32'h44444444, 0);
    do_op(4'd15, 32'h55555555, 32'h66666666, 2);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(10, 15));
      else op = 4'($urandom_range(0, 9));
      do_op(op, $urandom, $urandom, $urandom_range(0, 2));
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
